// File: rtl/can_bit_destuffer_pkg.sv
// Shared constants and state encoding for the CAN receive-side bit destuffer.
package can_bit_destuffer_pkg;

  localparam int unsigned CAN_STUFF_LEN = 5;
  localparam int unsigned CAN_IDLE_BITS = 11;

  typedef logic [1:0] destuff_state_e;

  localparam destuff_state_e DS_INTEGRATE = 2'd0;
  localparam destuff_state_e DS_BUS_IDLE  = 2'd1;
  localparam destuff_state_e DS_FRAME     = 2'd2;

  localparam logic [2:0] RUN_MAX = 3'd7;

  // Equal bit extends the run (saturating); a different bit starts a new run of one.
  function automatic logic [2:0] next_run(input logic [2:0] run, input logic same);
    if (!same) begin
      return 3'd1;
    end
    return (run == RUN_MAX) ? RUN_MAX : run + 3'd1;
  endfunction

endpackage

// File: rtl/can_bit_destuffer.sv
// CAN bit destuffer: bus integration, SOF detection, stuff-bit removal and
// stuff-error detection between the bit timing and the frame receiver.
module can_bit_destuffer
  import can_bit_destuffer_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN,
  parameter int unsigned IDLE_BITS = CAN_IDLE_BITS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_mode,
  input  logic       sample_point,
  input  logic       sampled_bit,
  input  logic       destuff_en,
  input  logic       error_clear,
  output logic       rx_bit,
  output logic       rx_bit_valid,
  output logic       remove_stuff_bit,
  output logic       stuff_error,
  output logic       stuff_error_sticky,
  output logic       sof_detect,
  output logic       bus_idle,
  output logic [2:0] run_cnt
);

  localparam int unsigned RecW = $clog2(IDLE_BITS + 1);
  localparam logic [RecW-1:0] IdleCnt = RecW'(IDLE_BITS);
  localparam logic [2:0] StuffCnt = 3'(STUFF_LEN);

  destuff_state_e  state_q, state_d;
  logic [RecW-1:0] rec_cnt_q, rec_cnt_d;
  logic [2:0]      run_cnt_q, run_cnt_d;
  logic            prev_bit_q, prev_bit_d;
  logic            rx_bit_q, rx_bit_d;
  logic            valid_q, valid_d;
  logic            remove_q, remove_d;
  logic            err_q, err_d;
  logic            sticky_q, sticky_d;
  logic            sof_q, sof_d;

  always_comb begin
    state_d    = state_q;
    rec_cnt_d  = rec_cnt_q;
    run_cnt_d  = run_cnt_q;
    prev_bit_d = prev_bit_q;
    rx_bit_d   = rx_bit_q;
    valid_d    = 1'b0;
    remove_d   = 1'b0;
    err_d      = 1'b0;
    sof_d      = 1'b0;

    if (reset_mode) begin
      state_d    = DS_INTEGRATE;
      rec_cnt_d  = '0;
      run_cnt_d  = '0;
      prev_bit_d = 1'b1;
      rx_bit_d   = 1'b1;
    end else if (sample_point) begin
      if (sampled_bit) begin
        rec_cnt_d = (rec_cnt_q == IdleCnt) ? rec_cnt_q : rec_cnt_q + RecW'(1);
      end else begin
        rec_cnt_d = '0;
      end

      case (state_q)
        DS_INTEGRATE: begin
          if (rec_cnt_d == IdleCnt) begin
            state_d = DS_BUS_IDLE;
          end
        end
        DS_BUS_IDLE: begin
          if (!sampled_bit) begin
            sof_d      = 1'b1;
            valid_d    = 1'b1;
            rx_bit_d   = 1'b0;
            run_cnt_d  = 3'd1;
            prev_bit_d = 1'b0;
            state_d    = DS_FRAME;
          end
        end
        DS_FRAME: begin
          if (destuff_en && run_cnt_q >= StuffCnt) begin
            if (sampled_bit != prev_bit_q) begin
              // Stuff bit opens the next run.
              remove_d   = 1'b1;
              run_cnt_d  = 3'd1;
              prev_bit_d = sampled_bit;
            end else begin
              err_d   = 1'b1;
              state_d = DS_INTEGRATE;
            end
          end else begin
            valid_d    = 1'b1;
            rx_bit_d   = sampled_bit;
            run_cnt_d  = next_run(run_cnt_q, sampled_bit == prev_bit_q);
            prev_bit_d = sampled_bit;
            if (!destuff_en && rec_cnt_d == IdleCnt) begin
              state_d = DS_BUS_IDLE;
            end
          end
        end
        default: state_d = DS_INTEGRATE;
      endcase
    end
  end

  // A new error wins over a simultaneous clear.
  assign sticky_d = err_d | (sticky_q & ~error_clear);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DS_INTEGRATE;
      rec_cnt_q  <= '0;
      run_cnt_q  <= '0;
      prev_bit_q <= 1'b1;
      rx_bit_q   <= 1'b1;
      valid_q    <= 1'b0;
      remove_q   <= 1'b0;
      err_q      <= 1'b0;
      sticky_q   <= 1'b0;
      sof_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rec_cnt_q  <= rec_cnt_d;
      run_cnt_q  <= run_cnt_d;
      prev_bit_q <= prev_bit_d;
      rx_bit_q   <= rx_bit_d;
      valid_q    <= valid_d;
      remove_q   <= remove_d;
      err_q      <= err_d;
      sticky_q   <= sticky_d;
      sof_q      <= sof_d;
    end
  end

  assign rx_bit             = rx_bit_q;
  assign rx_bit_valid       = valid_q;
  assign remove_stuff_bit   = remove_q;
  assign stuff_error        = err_q;
  assign stuff_error_sticky = sticky_q;
  assign sof_detect         = sof_q;
  assign bus_idle           = (state_q == DS_BUS_IDLE);
  assign run_cnt            = run_cnt_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Directed bench for can_bit_destuffer with hand-computed expectations.
module tb_can_bit_destuffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reset_mode = 1'b0;
  logic       sample_point = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       destuff_en = 1'b0;
  logic       error_clear = 1'b0;
  logic       rx_bit;
  logic       rx_bit_valid;
  logic       remove_stuff_bit;
  logic       stuff_error;
  logic       stuff_error_sticky;
  logic       sof_detect;
  logic       bus_idle;
  logic [2:0] run_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  can_bit_destuffer dut (
    .clk                (clk),
    .rst                (rst),
    .reset_mode         (reset_mode),
    .sample_point       (sample_point),
    .sampled_bit        (sampled_bit),
    .destuff_en         (destuff_en),
    .error_clear        (error_clear),
    .rx_bit             (rx_bit),
    .rx_bit_valid       (rx_bit_valid),
    .remove_stuff_bit   (remove_stuff_bit),
    .stuff_error        (stuff_error),
    .stuff_error_sticky (stuff_error_sticky),
    .sof_detect         (sof_detect),
    .bus_idle           (bus_idle),
    .run_cnt            (run_cnt)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One sample_point strobe; returns with outputs reflecting that sample.
  task automatic send(input logic b);
    @(posedge clk);
    #1;
    sample_point = 1'b1;
    sampled_bit  = b;
    @(posedge clk);
    #1;
    sample_point = 1'b0;
  endtask

  task automatic send_chk(input string tag, input logic b, input logic v, input logic rx,
                          input logic rem, input logic [2:0] run);
    send(b);
    check_eq({tag, ".valid"}, 8'(rx_bit_valid), 8'(v));
    check_eq({tag, ".rx"}, 8'(rx_bit), 8'(rx));
    check_eq({tag, ".remove"}, 8'(remove_stuff_bit), 8'(rem));
    check_eq({tag, ".run"}, 8'(run_cnt), 8'(run));
    check_eq({tag, ".err"}, 8'(stuff_error), 8'd0);
  endtask

  task automatic integrate(input string tag);
    for (int i = 0; i < 10; i++) send(1'b1);
    check_eq({tag, ".idle10"}, 8'(bus_idle), 8'd0);
    send(1'b1);
    check_eq({tag, ".idle11"}, 8'(bus_idle), 8'd1);
  endtask

  initial begin
    int vcnt;
    #12;
    check_eq("rst.rx", 8'(rx_bit), 8'd1);
    check_eq("rst.valid", 8'(rx_bit_valid), 8'd0);
    check_eq("rst.idle", 8'(bus_idle), 8'd0);
    check_eq("rst.run", 8'(run_cnt), 8'd0);
    check_eq("rst.sticky", 8'(stuff_error_sticky), 8'd0);
    rst = 1'b0;

    integrate("boot");

    // Stuff bit after five dominant bits
    destuff_en = 1'b1;
    send(1'b0);
    check_eq("sof.pulse", 8'(sof_detect), 8'd1);
    check_eq("sof.idle", 8'(bus_idle), 8'd0);
    check_eq("sof.rx", 8'(rx_bit), 8'd0);
    check_eq("sof.run", 8'(run_cnt), 8'd1);
    send_chk("d2", 1'b0, 1, 0, 0, 3'd2);
    check_eq("d2.sof_gone", 8'(sof_detect), 8'd0);
    send_chk("d3", 1'b0, 1, 0, 0, 3'd3);
    send_chk("d4", 1'b0, 1, 0, 0, 3'd4);
    send_chk("d5", 1'b0, 1, 0, 0, 3'd5);
    send_chk("stuff1", 1'b1, 0, 0, 1, 3'd1);
    send_chk("a1", 1'b1, 1, 1, 0, 3'd2);
    send_chk("a0", 1'b0, 1, 0, 0, 3'd1);

    // Recessive run, stuff 0, then the stuff bit starts the dominant run
    send_chk("r1", 1'b1, 1, 1, 0, 3'd1);
    send_chk("r2", 1'b1, 1, 1, 0, 3'd2);
    send_chk("r3", 1'b1, 1, 1, 0, 3'd3);
    send_chk("r4", 1'b1, 1, 1, 0, 3'd4);
    send_chk("r5", 1'b1, 1, 1, 0, 3'd5);
    send_chk("stuff0", 1'b0, 0, 1, 1, 3'd1);
    send_chk("z2", 1'b0, 1, 0, 0, 3'd2);
    send_chk("z3", 1'b0, 1, 0, 0, 3'd3);
    send_chk("z4", 1'b0, 1, 0, 0, 3'd4);
    send_chk("z5", 1'b0, 1, 0, 0, 3'd5);
    send(1'b0);
    check_eq("serr.pulse", 8'(stuff_error), 8'd1);
    check_eq("serr.valid", 8'(rx_bit_valid), 8'd0);
    check_eq("serr.sticky", 8'(stuff_error_sticky), 8'd1);
    @(posedge clk);
    #1;
    check_eq("serr.pulse_gone", 8'(stuff_error), 8'd0);
    error_clear = 1'b1;
    @(posedge clk);
    #1;
    error_clear = 1'b0;
    check_eq("clr.sticky", 8'(stuff_error_sticky), 8'd0);
    integrate("after_err");

    // Six dominant bits with error_clear held: set wins
    send(1'b0);
    for (int i = 0; i < 4; i++) send(1'b0);
    error_clear = 1'b1;
    send(1'b0);
    error_clear = 1'b0;
    check_eq("setwin.err", 8'(stuff_error), 8'd1);
    check_eq("setwin.sticky", 8'(stuff_error_sticky), 8'd1);
    check_eq("setwin.idle", 8'(bus_idle), 8'd0);
    error_clear = 1'b1;
    @(posedge clk);
    #1;
    error_clear = 1'b0;
    check_eq("setwin.clr", 8'(stuff_error_sticky), 8'd0);
    integrate("after_err2");

    // destuff_en drops with run at the limit: next bit is a normal bit
    send(1'b0);
    for (int i = 0; i < 4; i++) send(1'b0);
    check_eq("crc.run5", 8'(run_cnt), 8'd5);
    destuff_en = 1'b0;
    send_chk("crcdel", 1'b0, 1, 0, 0, 3'd6);
    check_eq("crcdel.sticky", 8'(stuff_error_sticky), 8'd0);
    vcnt = 0;
    for (int i = 0; i < 11; i++) begin
      send(1'b1);
      if (rx_bit_valid) vcnt++;
      if (i == 9) check_eq("eof.idle10", 8'(bus_idle), 8'd0);
    end
    check_eq("eof.valids", 8'(vcnt), 8'd11);
    check_eq("eof.idle11", 8'(bus_idle), 8'd1);
    check_eq("eof.run_sat", 8'(run_cnt), 8'd7);
    send(1'b0);
    check_eq("sof2.pulse", 8'(sof_detect), 8'd1);
    check_eq("sof2.run", 8'(run_cnt), 8'd1);

    // reset_mode mid-frame, no sample_point
    destuff_en = 1'b1;
    send_chk("rm.pre", 1'b0, 1, 0, 0, 3'd2);
    @(posedge clk);
    #1;
    reset_mode = 1'b1;
    @(posedge clk);
    #1;
    reset_mode = 1'b0;
    check_eq("rm.run", 8'(run_cnt), 8'd0);
    check_eq("rm.rx", 8'(rx_bit), 8'd1);
    check_eq("rm.valid", 8'(rx_bit_valid), 8'd0);
    check_eq("rm.idle", 8'(bus_idle), 8'd0);
    integrate("after_rm");

    // Asynchronous rst between clock edges
    send(1'b0);
    send(1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_eq("arst.run", 8'(run_cnt), 8'd0);
    check_eq("arst.rx", 8'(rx_bit), 8'd1);
    check_eq("arst.valid", 8'(rx_bit_valid), 8'd0);
    check_eq("arst.idle", 8'(bus_idle), 8'd0);
    #2;
    rst = 1'b0;
    integrate("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
